// File: rtl/id_pkg.sv
// Shared constants, control-bundle bit map and instruction field decode for the ID stage.
package id_pkg;

    localparam int unsigned CTRL_WIDTH    = 11;
    localparam int unsigned CTRL_REGDST   = 0;
    localparam int unsigned CTRL_ALUSRC   = 1;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_REGWRITE = 3;
    localparam int unsigned CTRL_MEMREAD  = 4;
    localparam int unsigned CTRL_MEMWRITE = 5;
    localparam int unsigned CTRL_BRANCH   = 6;
    localparam int unsigned CTRL_ALUOP_LO = 7;
    localparam int unsigned CTRL_ALUOP_HI = 10;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 26;
    localparam int unsigned RS_HI    = 25;
    localparam int unsigned RS_LO    = 21;
    localparam int unsigned RT_HI    = 20;
    localparam int unsigned RT_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 11;
    localparam int unsigned FUNCT_HI = 5;
    localparam int unsigned FUNCT_LO = 0;
    localparam int unsigned IMM_HI   = 15;
    localparam int unsigned IMM_LO   = 0;

    // All-ones pattern; truncated to the counter width to get the saturation value.
    localparam logic [63:0] CNT_SAT_FULL = '1;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.opcode = instr[OPC_HI:OPC_LO];
        f.rs     = instr[RS_HI:RS_LO];
        f.rt     = instr[RT_HI:RT_LO];
        f.rd     = instr[RD_HI:RD_LO];
        f.funct  = instr[FUNCT_HI:FUNCT_LO];
        f.imm    = instr[IMM_HI:IMM_LO];
        return f;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with r0 hardwired to zero and write-through bypass on both read ports.
module regfile_bypass #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wb_en,
    input  logic [$clog2(NREGS)-1:0]  wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    input  logic [$clog2(NREGS)-1:0]  rs_addr,
    input  logic [$clog2(NREGS)-1:0]  rt_addr,
    output logic [XLEN-1:0]           rs_data_c,
    output logic [XLEN-1:0]           rt_data_c
);

    logic [XLEN-1:0] regs [NREGS];

    // Write port; r0 is never written so it reads back as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read ports; a same-cycle write to the addressed register is forwarded.
    always_comb begin
        rs_data_c = '0;
        rt_data_c = '0;
        if (rs_addr != '0) begin
            rs_data_c = (wb_en && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data_c = (wb_en && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register read, immediate/branch-target generation, and the ID/EX
// pipeline register with load-use stall, branch flush and saturating event counters.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned CTRL_W = CTRL_WIDTH,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [31:0]               in_instr,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic                      flush,
    input  logic                      wb_en,
    input  logic [$clog2(NREGS)-1:0]  wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_rs_data,
    output logic [XLEN-1:0]           out_rt_data,
    output logic [XLEN-1:0]           out_imm,
    output logic [4:0]                out_rs,
    output logic [4:0]                out_rt,
    output logic [4:0]                out_rd,
    output logic [5:0]                out_opcode,
    output logic [5:0]                out_funct,
    output logic [XLEN-1:0]           out_branch_target,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_SAT_FULL);

    instr_fields_t      fields;
    logic [XLEN-1:0]    rs_data;
    logic [XLEN-1:0]    rt_data;
    logic signed [15:0] imm_s;
    logic [XLEN-1:0]    imm_ext;
    logic [XLEN-1:0]    branch_target;
    logic               hazard;
    logic               accept;
    logic               stall_ev;

    assign fields = decode_fields(in_instr);

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rs_addr   (fields.rs[AW-1:0]),
        .rt_addr   (fields.rt[AW-1:0]),
        .rs_data_c (rs_data),
        .rt_data_c (rt_data)
    );

    assign imm_s         = fields.imm;
    assign imm_ext       = XLEN'(imm_s);
    assign branch_target = in_pc + (imm_ext << 2);

    // Load in ID/EX whose destination feeds this instruction; rt match is conservative.
    assign hazard = in_valid && out_valid && out_ctrl[CTRL_MEMREAD] && (out_rt != 5'd0)
                    && ((out_rt == fields.rs) || (out_rt == fields.rt));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign stall_ev = !flush && hazard && out_ready;

    // ID/EX register; payload is only written on accept so it stays stable while held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_rs_data       <= '0;
            out_rt_data       <= '0;
            out_imm           <= '0;
            out_rs            <= '0;
            out_rt            <= '0;
            out_rd            <= '0;
            out_opcode        <= '0;
            out_funct         <= '0;
            out_branch_target <= '0;
            out_ctrl          <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid         <= 1'b1;
            out_rs_data       <= rs_data;
            out_rt_data       <= rt_data;
            out_imm           <= imm_ext;
            out_rs            <= fields.rs;
            out_rt            <= fields.rt;
            out_rd            <= fields.rd;
            out_opcode        <= fields.opcode;
            out_funct         <= fields.funct;
            out_branch_target <= branch_target;
            out_ctrl          <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush && (flush_cnt != CNT_SAT)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (stall_ev && (stall_cnt != CNT_SAT)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with a per-cycle reference model and literal spot checks.
module tb_id_stage_pipe;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned CTRL_W = 11;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rs_data, out_rt_data, out_imm, out_branch_target;
    logic [4:0]        out_rs, out_rt, out_rd;
    logic [5:0]        out_opcode, out_funct;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    logic              s_in_ready, s_out_valid;
    logic [XLEN-1:0]   s_rs_data, s_rt_data, s_imm, s_tgt;
    logic [4:0]        s_rs, s_rt, s_rd;
    logic [5:0]        s_opcode, s_funct;
    logic [CTRL_W-1:0] s_ctrl;
    logic [1:0]        s_stall_cnt, s_flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct(out_funct),
        .out_branch_target(out_branch_target), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W), .CNT_W(2)) u_small (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_rs_data(s_rs_data), .out_rt_data(s_rt_data), .out_imm(s_imm),
        .out_rs(s_rs), .out_rt(s_rt), .out_rd(s_rd),
        .out_opcode(s_opcode), .out_funct(s_funct),
        .out_branch_target(s_tgt), .out_ctrl(s_ctrl),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model state
    logic [31:0] rf [32];
    logic        m_valid;
    logic [31:0] m_rs_data, m_rt_data, m_imm, m_tgt;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_op, m_fn;
    logic [10:0] m_ctrl;
    int          m_scnt, m_fcnt;

    function automatic logic [31:0] rd_model(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return rf[idx];
    endfunction

    function automatic logic exp_hazard();
        logic [4:0] rs, rt;
        rs = in_instr[25:21];
        rt = in_instr[20:16];
        return in_valid && m_valid && m_ctrl[4] && (m_rt != 0) && (m_rt == rs || m_rt == rt);
    endfunction

    function automatic logic exp_ready();
        return !flush && !exp_hazard() && (!m_valid || out_ready);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf[i] = '0;
            m_valid = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_tgt = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_op = 0; m_fn = 0; m_ctrl = 0;
            m_scnt = 0; m_fcnt = 0;
        end else begin
            logic        hz, rdy;
            logic signed [31:0] sx;
            hz = exp_hazard();
            rdy = exp_ready();
            if (flush) begin
                m_valid = 0;
                m_fcnt++;
            end else if (in_valid && rdy) begin
                sx = $signed(in_instr[15:0]);
                m_valid   = 1;
                m_rs      = in_instr[25:21];
                m_rt      = in_instr[20:16];
                m_rd      = in_instr[15:11];
                m_op      = in_instr[31:26];
                m_fn      = in_instr[5:0];
                m_rs_data = rd_model(m_rs);
                m_rt_data = rd_model(m_rt);
                m_imm     = sx;
                m_tgt     = in_pc + sx * 4;
                m_ctrl    = in_ctrl;
            end else if (hz && out_ready) begin
                m_valid = 0;
                m_scnt++;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, m_valid);
        chk("rs_data", out_rs_data, m_rs_data);
        chk("rt_data", out_rt_data, m_rt_data);
        chk("imm", out_imm, m_imm);
        chk("target", out_branch_target, m_tgt);
        chk("fields", {out_rs, out_rt, out_rd, out_opcode, out_funct}, {m_rs, m_rt, m_rd, m_op, m_fn});
        chk("ctrl", out_ctrl, m_ctrl);
        chk("stall_cnt", stall_cnt, sat(m_scnt, 65535));
        chk("flush_cnt", flush_cnt, sat(m_fcnt, 65535));
        chk("small_valid", s_out_valid, m_valid);
        chk("small_stall", s_stall_cnt, sat(m_scnt, 3));
        chk("small_flush", s_flush_cnt, sat(m_fcnt, 3));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [10:0] ctrl, input logic [31:0] pc);
        in_valid = 1; in_instr = instr; in_ctrl = ctrl; in_pc = pc;
    endtask

    localparam logic [10:0] C_RTYPE = 11'h109;
    localparam logic [10:0] C_LW    = 11'h01E;
    localparam logic [10:0] C_BEQ   = 11'h0C0;

    initial begin
        logic [4:0]  hold_rd;
        logic [31:0] hold_data;
        idle();
        in_instr = 0; in_ctrl = 0; in_pc = 0;
        reset_n = 0;
        repeat (3) cyc();
        @(negedge clk);
        chk("lit_rst_valid", out_valid, 0);
        chk("lit_rst_cnt", {stall_cnt, flush_cnt}, 0);
        cyc(); reset_n = 1;

        // read r4 with no writes
        cyc(); present(32'h00843020, C_RTYPE, 32'h40);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("lit_r4_zero", out_rs_data, 0);
        chk("lit_r4_valid", out_valid, 1);

        // same-cycle write-back bypass
        cyc(); present(32'h00A53020, C_RTYPE, 32'h44);
        wb_en = 1; wb_addr = 5; wb_data = 32'hAAAA5555;
        cyc(); idle();
        @(negedge clk);
        chk("lit_bypass_rs", out_rs_data, 32'hAAAA5555);
        chk("lit_bypass_rt", out_rt_data, 32'hAAAA5555);

        // load-use stall
        cyc(); present(32'h8C880000, C_LW, 32'h48);
        cyc(); present(32'h01084820, C_RTYPE, 32'h4C);
        @(negedge clk);
        chk("lit_lu_ready", in_ready, 0);
        cyc();
        @(negedge clk);
        chk("lit_lu_bubble", out_valid, 0);
        chk("lit_lu_stall", stall_cnt, 1);
        chk("lit_lu_ready2", in_ready, 1);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("lit_lu_rd", out_rd, 9);

        // back-pressure hold
        cyc(); present(32'h00223820, C_RTYPE, 32'h50);
        cyc(); out_ready = 0; present(32'h00432020, C_RTYPE, 32'h54);
        @(negedge clk);
        hold_rd = out_rd; hold_data = out_branch_target;
        repeat (3) begin
            cyc();
            @(negedge clk);
            chk("lit_hold_rd", out_rd, hold_rd);
            chk("lit_hold_tgt", out_branch_target, hold_data);
            chk("lit_hold_ready", in_ready, 0);
        end
        cyc(); out_ready = 1;
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("lit_hold_next", out_rd, 4);
        chk("lit_hold_stall", stall_cnt, 1);

        // hazard under back-pressure counts no stall until the bubble
        cyc(); present(32'h8C880000, C_LW, 32'h58);
        cyc(); present(32'h01084820, C_RTYPE, 32'h5C); out_ready = 0;
        repeat (2) cyc();
        @(negedge clk);
        chk("lit_bp_nostall", stall_cnt, 1);
        cyc(); out_ready = 1;
        cyc();
        @(negedge clk);
        chk("lit_bp_stall", stall_cnt, 2);
        cyc(); in_valid = 0;

        // flush with concurrent write-back
        cyc(); present(32'h00223820, C_RTYPE, 32'h60); out_ready = 0;
        cyc(); present(32'h00432020, C_RTYPE, 32'h64); flush = 1;
        wb_en = 1; wb_addr = 10; wb_data = 32'hDEADBEEF;
        cyc(); idle();
        @(negedge clk);
        chk("lit_flush_valid", out_valid, 0);
        chk("lit_flush_cnt", flush_cnt, 1);
        cyc(); present(32'h01405820, C_RTYPE, 32'h68);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("lit_r10", out_rs_data, 32'hDEADBEEF);

        // branch target with negative immediate
        cyc(); present(32'h1022FFFF, C_BEQ, 32'h100);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("lit_target", out_branch_target, 32'h000000FC);
        chk("lit_imm", out_imm, 32'hFFFFFFFF);

        // r0 writes ignored, including same-cycle bypass
        cyc(); present(32'h00000020, C_RTYPE, 32'h104);
        wb_en = 1; wb_addr = 0; wb_data = 32'h12345678;
        cyc(); idle();
        @(negedge clk);
        chk("lit_r0_bypass", out_rs_data, 0);
        cyc(); present(32'h00000020, C_RTYPE, 32'h108);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("lit_r0_read", {out_rs_data, out_rt_data}, 0);

        // five flushes: narrow counter saturates
        cyc(); flush = 1; present(32'h00223820, C_RTYPE, 32'h10C);
        repeat (5) cyc();
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("lit_sat_small", s_flush_cnt, 3);
        chk("lit_sat_big", flush_cnt, 6);

        // reset during a flush clears state and register file
        cyc(); flush = 1; present(32'h8C880000, C_LW, 32'h110);
        cyc(); reset_n = 0;
        @(negedge clk);
        chk("lit_rst_flush", flush_cnt, 0);
        chk("lit_rst_valid2", out_valid, 0);
        cyc(); reset_n = 1; idle();
        cyc(); present(32'h01405820, C_RTYPE, 32'h114);
        cyc(); in_valid = 0;
        @(negedge clk);
        chk("lit_rst_r10", out_rs_data, 0);

        repeat (3) cyc();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor of the single-cycle decode stage.
- Combines a register file (XLEN x NREGS, r0 hardwired zero, write-through bypass), instruction field decode and sign-extend/branch-target logic.
- Adds a registered ID/EX pipeline register with valid/ready handshake, load-use hazard stall with bubble insertion, branch flush, and saturating stall/flush event counters.
- Sits between the IF/ID register and the EX stage of the 5-stage pipeline.

Parameters:
- XLEN, 32, datapath width (>=16)
- NREGS, 32, register count; power of 2, 2..32
- CTRL_W, 11, control bundle width; fixed by package layout
- CNT_W, 16, event counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  PC+4 of the instruction
- in_instr  in  32  instruction word
- in_ctrl  in  CTRL_W  control bundle from the control unit
- flush  in  1  branch resolved taken: kill the ID and ID/EX contents
- wb_en  in  1  write-back enable
- wb_addr  in  log2(NREGS)  write-back register index
- wb_data  in  XLEN  write-back data
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  EX consumes the entry this cycle
- out_rs_data, out_rt_data  out  XLEN  operand values
- out_imm  out  XLEN  sign-extended instr[15:0]
- out_rs, out_rt, out_rd  out  5  register fields
- out_opcode, out_funct  out  6  instr[31:26] and instr[5:0]
- out_branch_target  out  XLEN  in_pc + (sext(imm) << 2), modulo 2^XLEN
- out_ctrl  out  CTRL_W  registered control bundle
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (reset_n low, async): all registers = 0; out_valid = 0; every payload output = 0; both counters = 0. Reset during a stall or flush clears everything; no pending state survives.
- Register write: on posedge when wb_en && wb_addr != 0. A write to r0 is ignored; reads of r0 always return 0. wb_addr >= NREGS is ignored. Writes proceed regardless of stall, flush or handshake state.
- Register read: combinational. Bypass rule: if wb_en && wb_addr == rs && rs != 0, the read returns wb_data; the same rule applies to rt. Register indices use the low log2(NREGS) bits of each field.
- Hazard (load-use): hazard = out_valid && out_ctrl[MEMREAD] && out_rt != 0 && (out_rt == in rs || out_rt == in rt); matching on rt is always conservative. Hazard is evaluated only when in_valid is high.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- ID/EX update, evaluated in priority order each posedge:
  1. flush: out_valid <= 0; incoming instruction dropped; flush_cnt += 1.
  2. in_valid && in_ready: load payload; out_valid <= 1. Latency is 1 cycle.
  3. hazard && out_ready: out_valid <= 0 (bubble); stall_cnt += 1.
  4. out_ready && out_valid: out_valid <= 0.
  5. Otherwise: hold the entry. Payload stays stable while out_valid && !out_ready.
- A hazard while EX is back-pressured holds the load in ID/EX and counts no stall. The stall is counted in the cycle the bubble is inserted.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- Payload registers are not cleared on bubble or flush; only out_valid drops.

Decomposition:
- Package id_pkg holds:
  - CTRL_W and control bit indices: REGDST=0, ALUSRC=1, MEMTOREG=2, REGWRITE=3, MEMREAD=4, MEMWRITE=5, BRANCH=6, ALUOP=10:7.
  - Instruction field bit positions.
  - Counter saturate constant.
- Sub-module regfile_bypass (parameters XLEN, NREGS) contains the array, write port, r0 rule and both bypassed read ports.
- Hazard detection, ID/EX register and counters stay in id_stage_pipe.

Test Plan:
- Reset, then read r4 with no writes -> out_rs_data = 0 after accept; counters = 0; out_valid = 0 during reset.
- wb_en=1, wb_addr=5, wb_data=32'hAAAA5555 in the same cycle as instr 32'h00A53020 (add r6,r5,r5) accepted -> next cycle out_rs_data = out_rt_data = 32'hAAAA5555 via bypass.
- lw r8,0(r4) accepted, then add r9,r8,r8 presented with out_ready=1 -> in_ready=0 for one cycle, one bubble (out_valid=0), stall_cnt=1; add is accepted the following cycle.
- Valid entry held with out_ready=0 for 3 cycles -> all outputs stable, in_ready=0, no counter change; out_ready=1 -> next entry loads.
- flush asserted with in_valid=1 and a valid ID/EX entry -> next cycle out_valid=0, instruction not loaded, flush_cnt=1; a simultaneous wb write to r10=32'hDEADBEEF still lands.
- in_pc=32'h00000100, imm=16'hFFFF -> out_branch_target=32'h000000FC; wb to r0 with 32'h12345678 -> later read of r0 returns 0; force CNT_W=2 and run 5 flushes -> flush_cnt=3.
